csr_scan_sequencer: RTL and testbench
=====================================

// Module: csr_scan_sequencer
// PURPOSE
//  Host-side controller for the CSR bank scan chain and processor run state.
//  - Serialises host bytes into the chain (scan_enable/scan_in) while deserialising the displaced bits (scan_out) back to the host.
//  - Gates processor_enable with RUN/HALT/STEP commands, so the chain is never shifted while the core runs.
// PARAMETERS
//  WIDTH     8  bits per CSR and per host byte
//  NUM_REGS  8  registers in the scan chain
//  (localparam CHAIN_LEN = WIDTH*NUM_REGS = 64; CNT_W = $clog2(CHAIN_LEN+1))
// PORTS
//  clk              in   1      clock; single clock domain
//  rst              in   1      synchronous, active-high reset
//  cmd_valid        in   1      command offered
//  cmd_ready        out  1      command accepted when cmd_valid&cmd_ready
//  cmd_op           in   2      00 SHIFT, 01 RUN, 10 HALT, 11 STEP
//  cmd_error        out  1      1-cycle pulse: illegal command dropped
//  din              in   WIDTH  byte to load into chain
//  din_valid        in   1      din offered
//  din_ready        out  1      din accepted when din_valid&din_ready
//  dout             out  WIDTH  byte shifted out of chain
//  dout_valid       out  1      dout held until dout_ready
//  dout_ready       in   1      host takes dout
//  scan_enable      out  1      chain shift strobe
//  scan_in          out  1      serial bit into chain head
//  scan_out         in   1      serial bit from chain tail
//  processor_enable out  1      core run gate
//  shift_done       out  1      1-cycle pulse at end of SHIFT
// BEHAVIOUR
//  Reset values:
//  - State HALTED; processor_enable=0, scan_enable=0, scan_in=0.
//  - cmd_ready=1, din_ready=0, dout_valid=0, dout=0, cmd_error=0, shift_done=0.
//  - Bit counter 0; both byte buffers empty.
//  FSM states: HALTED, SHIFT, RUNNING, STEP.
//  - cmd_ready=1 in HALTED and RUNNING, 0 in SHIFT and STEP.
//  - HALTED + SHIFT -> SHIFT.  HALTED + RUN -> RUNNING; processor_enable=1 from the next cycle.
//  - HALTED + HALT -> no-op.  RUNNING + HALT -> HALTED; processor_enable=0 from the next cycle.
//  - RUNNING + RUN -> no-op.  RUNNING + SHIFT or STEP -> cmd_error pulse; state unchanged.
//  SHIFT state:
//  - din_ready=1 while the input buffer is empty.
//  - A shift cycle happens only when the input buffer is full AND the output buffer is not holding an unaccepted byte.
//    - In a shift cycle: scan_enable=1, scan_in = input bit[k] (k=0 first, LSB first), scan_out sampled into output bit[k] in the same cycle.
//    - Otherwise scan_enable=0 and the chain holds (stall; no bit lost).
//  - After WIDTH shift cycles: input buffer empties; output byte presented on dout with dout_valid=1 the next cycle.
//  - din may be accepted in the same cycle the previous byte's last bit shifts.
//  - After CHAIN_LEN shifts and acceptance of the final dout byte:
//    - shift_done pulses, state -> HALTED.
//    - Bytes in = bytes out = NUM_REGS; byte n out is the chain content displaced by byte n in.
//  Common rules:
//  - processor_enable is always 0 outside RUNNING/STEP. scan_enable and processor_enable are never 1 together.
//  - rst in any state, including mid-SHIFT, returns all outputs to reset values in the next cycle.
//    - A partially consumed byte is discarded; the CSR chain is reset by the same rst.
//  - Counter arithmetic is CNT_W unsigned; terminal compare is == CHAIN_LEN; no wrap.
// CONFIGURATION
//  CSR_SCAN_SEQ_STEP_EN defined:
//  - HALTED + STEP -> STEP: processor_enable=1 for exactly one cycle, then HALTED. cmd_ready=0 during that cycle.
//  CSR_SCAN_SEQ_STEP_EN undefined:
//  - op 11 -> cmd_error pulse in every state; the STEP state is not built.
// STRUCTURE
//  Package csr_scan_seq_pkg:
//  - Op-code constants OP_SHIFT/OP_RUN/OP_HALT/OP_STEP.
//  - State encoding typedef seq_state_t.
//  Sub-module scan_byte_serdes:
//  - Input byte buffer plus output byte buffer with bit index and valid/ready logic.
//  - Driven by a shift_ok qualifier from the top FSM.
//  Top level holds the FSM, bit counter, and processor_enable/cmd_error/shift_done generation.
// TESTING
//  - Reset, idle 5 cycles -> processor_enable=0, scan_enable=0, cmd_ready=1, dout_valid=0.
//  - SHIFT with bytes 01..08, dout_ready=1, then SHIFT with 00 x8:
//    - First shift: dout = 8 zero bytes (post-reset chain), shift_done once.
//    - Second shift: dout = 01..08 in order (round trip).
//  - SHIFT with din_valid gapped 3 cycles/byte and dout_ready held low 10 cycles on byte 4:
//    - scan_enable low during every stall, exactly 64 scan_enable cycles total, data intact.
//  - RUN -> processor_enable=1 next cycle; SHIFT while RUNNING -> cmd_error pulse, no scan_enable.
//    HALT -> processor_enable=0 next cycle.
//  - STEP from HALTED:
//    - With CSR_SCAN_SEQ_STEP_EN: processor_enable high exactly 1 cycle.
//    - Without the macro: cmd_error pulse, processor_enable stays 0.
//  - rst asserted after 20 shifts of a SHIFT -> HALTED next cycle, all outputs at reset values; new SHIFT completes normally.

Source files
------------

// File: rtl/csr_scan_seq_pkg.sv
// Shared op-codes and state encoding for the CSR scan-chain sequencer.
package csr_scan_seq_pkg;

  localparam logic [1:0] OP_SHIFT = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_HALT  = 2'b10;
  localparam logic [1:0] OP_STEP  = 2'b11;

  typedef enum logic [1:0] {
    ST_HALTED  = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_RUNNING = 2'd2,
    ST_STEP    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/scan_byte_serdes.sv
// Byte-wide serialiser/deserialiser between the host handshakes and the scan chain.
// Input byte goes out LSB first; displaced chain bits are gathered into the output byte.
module scan_byte_serdes #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept_en,
  input  logic             shift_ok,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             scan_in,
  input  logic             scan_out,
  output logic             in_full
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] in_buf;
  logic [WIDTH-1:0] out_buf;
  logic [WIDTH-1:0] out_next;
  logic [IDX_W-1:0] bit_idx;
  logic             last_bit;

  assign last_bit  = (bit_idx == IDX_W'(WIDTH - 1));
  // The next byte may land in the same cycle the current byte's last bit leaves.
  assign din_ready = accept_en & (~in_full | (shift_ok & last_bit));
  assign scan_in   = shift_ok & in_buf[bit_idx];

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    out_next          = out_buf;
    out_next[bit_idx] = scan_out;
  end

  // NOTE: the data buffers are reset too; they are a handful of flops and dout must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_buf     <= '0;
      out_buf    <= '0;
      bit_idx    <= '0;
      in_full    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (dout_valid && dout_ready) dout_valid <= 1'b0;
      if (shift_ok) begin
        out_buf <= out_next;
        if (last_bit) begin
          bit_idx    <= '0;
          in_full    <= 1'b0;
          dout       <= out_next;
          dout_valid <= 1'b1;
        end else begin
          bit_idx <= bit_idx + IDX_W'(1);
        end
      end
      if (din_valid && din_ready) begin
        in_buf  <= din;
        in_full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/csr_scan_sequencer.sv
// CSR scan-chain sequencer: run/halt gating of the core plus byte-wise chain shifting.
// Optional single-step command built when CSR_SCAN_SEQ_STEP_EN is defined.
module csr_scan_sequencer
  import csr_scan_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  output logic             cmd_error,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             scan_enable,
  output logic             scan_in,
  input  logic             scan_out,
  output logic             processor_enable,
  output logic             shift_done
);

  localparam int CHAIN_LEN = WIDTH * NUM_REGS;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

  seq_state_t       state, state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic             cmd_fire, chain_full, in_full, shift_ok, accept_en;
  logic             err_next, done_next;

  assign cmd_fire   = cmd_valid & cmd_ready;
  assign chain_full = (bit_cnt == CNT_W'(CHAIN_LEN));
  assign shift_ok   = (state == ST_SHIFT) & in_full & ~dout_valid;
  // Stop taking bytes once the bytes already committed cover the whole chain.
  assign accept_en  = (state == ST_SHIFT) &
                      (in_full ? ((bit_cnt + CNT_W'(1)) < CNT_W'(CHAIN_LEN)) : ~chain_full);

  assign cmd_ready        = (state == ST_HALTED) | (state == ST_RUNNING);
  assign scan_enable      = shift_ok;
  assign processor_enable = (state == ST_RUNNING) | (state == ST_STEP);

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    done_next  = 1'b0;
    unique case (state)
      ST_HALTED: if (cmd_fire) begin
        unique case (cmd_op)
          OP_SHIFT: state_next = ST_SHIFT;
          OP_RUN:   state_next = ST_RUNNING;
          OP_HALT:  state_next = ST_HALTED;
`ifdef CSR_SCAN_SEQ_STEP_EN
          OP_STEP:  state_next = ST_STEP;
`else
          OP_STEP:  err_next   = 1'b1;
`endif
        endcase
      end
      ST_RUNNING: if (cmd_fire) begin
        unique case (cmd_op)
          OP_RUN:  state_next = ST_RUNNING;
          OP_HALT: state_next = ST_HALTED;
          default: err_next   = 1'b1;
        endcase
      end
      ST_SHIFT: if (chain_full && dout_valid && dout_ready) begin
        state_next = ST_HALTED;
        done_next  = 1'b1;
      end
`ifdef CSR_SCAN_SEQ_STEP_EN
      ST_STEP: state_next = ST_HALTED;
`endif
      default: state_next = ST_HALTED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_HALTED;
      bit_cnt    <= '0;
      cmd_error  <= 1'b0;
      shift_done <= 1'b0;
    end else begin
      state      <= state_next;
      cmd_error  <= err_next;
      shift_done <= done_next;
      if (done_next)     bit_cnt <= '0;
      else if (shift_ok) bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  scan_byte_serdes #(.WIDTH(WIDTH)) u_serdes (
    .clk        (clk),
    .rst        (rst),
    .accept_en  (accept_en),
    .shift_ok   (shift_ok),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
    .in_full    (in_full)
  );

endmodule

// File: tb/tb_csr_scan_sequencer.sv
// Bench for csr_scan_sequencer: a 64-bit chain model, a byte-level scoreboard
// (each SHIFT returns the bytes of the previous SHIFT, zeros after reset) and directed command tests.
module tb_csr_scan_sequencer;
  import csr_scan_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_error;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] din = 8'h00, dout;
  logic       din_valid = 1'b0, din_ready, dout_valid, dout_ready = 1'b1;
  logic       scan_enable, scan_in, scan_out, processor_enable, shift_done;

  int checks = 0;
  int errors = 0;
  int se_cnt = 0, acc = 0, outs = 0, done_cnt = 0;
  bit abort = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  logic [7:0] model_bytes[8];
  logic [63:0] chain = '0;
  logic se_q = 1'b0, si_q = 1'b0;

  always #5 clk = ~clk;

  csr_scan_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_error(cmd_error), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .scan_enable(scan_enable),
    .scan_in(scan_in), .scan_out(scan_out), .processor_enable(processor_enable),
    .shift_done(shift_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // CSR chain model: head takes scan_in, tail drives scan_out, cleared by rst.
  assign scan_out = chain[63];
  always @(negedge clk) begin
    se_q = scan_enable;
    si_q = scan_in;
  end
  always @(posedge clk) begin
    if (rst)       chain <= '0;
    else if (se_q) chain <= {chain[62:0], si_q};
  end

  // Per-cycle compare against the scoreboard and the shift rules.
  always @(negedge clk) begin
    if (rst) begin
      se_cnt = 0; acc = 0; outs = 0; done_cnt = 0;
      exp_q.delete();
      got.delete();
    end else begin
      check("se_pe_exclusive", scan_enable & processor_enable, 0);
      if (scan_enable) begin
        check("se_while_dout_held", dout_valid, 0);
        check("se_with_data", (acc * 8 > se_cnt), 1);
        se_cnt++;
      end
      if (din_valid && din_ready) acc++;
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) check("dout_unexpected", 1, 0);
        else check("dout_byte", dout, exp_q.pop_front());
        got.push_back(dout);
        outs++;
      end
      if (shift_done) done_cnt++;
    end
  end

  task automatic check_reset_outputs();
    check("rst_pe", processor_enable, 0);
    check("rst_se", scan_enable, 0);
    check("rst_scan_in", scan_in, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_din_ready", din_ready, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_cmd_error", cmd_error, 0);
    check("rst_shift_done", shift_done, 0);
  endtask

  task automatic send_cmd(input logic [1:0] op);
    cmd_op = op;
    cmd_valid = 1'b1;
    @(negedge clk);
    check("cmd_ready_at_issue", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic feed_bytes(input logic [7:0] b[8], input int gap);
    bit hs;
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gap && !abort; g++) begin @(posedge clk); #1; end
      if (abort) return;
      din = b[i];
      din_valid = 1'b1;
      hs = 1'b0;
      for (int t = 0; t < 500 && !hs && !abort; t++) begin
        @(negedge clk);
        hs = din_ready;
        @(posedge clk); #1;
      end
      din_valid = 1'b0;
      if (abort) return;
      if (!hs) begin
        check("din_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic consume(input bit stall);
    if (!stall) return;
    for (int t = 0; t < 2000 && outs < 3; t++) begin @(posedge clk); #1; end
    dout_ready = 1'b0;
    for (int t = 0; t < 2000 && !dout_valid; t++) begin @(posedge clk); #1; end
    check("stall_byte4_valid", dout_valid, 1);
    repeat (10) begin @(posedge clk); #1; end
    dout_ready = 1'b1;
  endtask

  task automatic start_shift(input logic [7:0] b[8]);
    for (int i = 0; i < 8; i++) exp_q.push_back(model_bytes[i]);
    model_bytes = b;
    se_cnt = 0; acc = 0; outs = 0; done_cnt = 0;
    got.delete();
    send_cmd(OP_SHIFT);
    @(negedge clk);
    check("shift_cmd_ready_low", cmd_ready, 0);
    @(posedge clk); #1;
  endtask

  task automatic do_shift(input logic [7:0] b[8], input int gap, input bit stall);
    start_shift(b);
    fork
      feed_bytes(b, gap);
      consume(stall);
    join
    for (int t = 0; t < 2000 && done_cnt == 0; t++) begin @(posedge clk); #1; end
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("shift_done_count", done_cnt, 1);
    check("scan_enable_cycles", se_cnt, 64);
    check("bytes_out", outs, 8);
    check("scoreboard_empty", exp_q.size(), 0);
    check("after_shift_cmd_ready", cmd_ready, 1);
    check("after_shift_pe", processor_enable, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_got(input string tag, input logic [7:0] e[8]);
    check({tag, "_count"}, got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) check(tag, got[i], e[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] zeros[8];
    logic [7:0] seq_a[8];
    logic [7:0] seq_c[8];
    logic [7:0] seq_r[8];
    logic [7:0] seq_n[8];
    zeros = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    seq_a = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    seq_c = '{8'hA1, 8'h5A, 8'hC3, 8'h80, 8'h7E, 8'h01, 8'hFF, 8'h3C};
    seq_r = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
    seq_n = '{8'h96, 8'h69, 8'hF0, 8'h0F, 8'h55, 8'hAA, 8'h11, 8'hEE};
    model_bytes = zeros;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;

    do_shift(seq_a, 0, 1'b0);
    check_got("post_reset_chain", zeros);
    do_shift(zeros, 0, 1'b0);
    check_got("round_trip", seq_a);

    do_shift(seq_c, 3, 1'b1);
    check_got("stalled_out", zeros);
    do_shift(zeros, 0, 1'b0);
    check_got("stalled_data", seq_c);

    send_cmd(OP_RUN);
    @(negedge clk);
    check("run_pe", processor_enable, 1);
    check("run_err", cmd_error, 0);
    @(posedge clk); #1;
    send_cmd(OP_RUN);
    @(negedge clk);
    check("run_run_pe", processor_enable, 1);
    check("run_run_err", cmd_error, 0);
    @(posedge clk); #1;
    send_cmd(OP_SHIFT);
    @(negedge clk);
    check("run_shift_err", cmd_error, 1);
    check("run_shift_pe", processor_enable, 1);
    check("run_shift_se", scan_enable, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("run_shift_err_pulse", cmd_error, 0);
    check("run_shift_se2", scan_enable, 0);
    check("run_still_ready", cmd_ready, 1);
    @(posedge clk); #1;
    send_cmd(OP_HALT);
    @(negedge clk);
    check("halt_pe", processor_enable, 0);
    check("halt_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;

    send_cmd(OP_STEP);
    @(negedge clk);
`ifdef CSR_SCAN_SEQ_STEP_EN
    check("step_pe_on", processor_enable, 1);
    check("step_cmd_ready", cmd_ready, 0);
    check("step_err", cmd_error, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("step_pe_off", processor_enable, 0);
    check("step_back_halted", cmd_ready, 1);
`else
    check("step_err", cmd_error, 1);
    check("step_pe", processor_enable, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("step_err_pulse", cmd_error, 0);
    check("step_pe_still_off", processor_enable, 0);
`endif
    @(posedge clk); #1;

    // Reset in the middle of a SHIFT, after exactly 20 chain shifts.
    start_shift(seq_r);
    fork
      feed_bytes(seq_r, 0);
      begin
        for (int t = 0; t < 1000 && se_cnt < 20; t++) begin @(posedge clk); #1; end
        check("mid_shift_reached", (se_cnt >= 20), 1);
        rst = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
    join
    abort = 1'b0;
    model_bytes = zeros;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;

    do_shift(seq_n, 0, 1'b0);
    check_got("after_mid_rst", zeros);
    do_shift(zeros, 0, 1'b0);
    check_got("after_mid_rst_rt", seq_n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
